// File: rtl/mult_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// FSM states, iteration count and the Booth recoding table.
package mult_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ACC_W      = 34;
    localparam int unsigned ITER_COUNT = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Recoding triplet {Q[1], Q[0], QM1}
    typedef enum logic [2:0] {
        OP_ZERO_A  = 3'b000,
        OP_ADD_M_A = 3'b001,
        OP_ADD_M_B = 3'b010,
        OP_ADD_2M  = 3'b011,
        OP_SUB_2M  = 3'b100,
        OP_SUB_M_A = 3'b101,
        OP_SUB_M_B = 3'b110,
        OP_ZERO_B  = 3'b111
    } booth_op_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_M,
        SEL_2M
    } booth_sel_t;

    typedef struct packed {
        booth_sel_t sel;
        logic       sub;
    } booth_ctrl_t;

    // Map a recoding triplet to addend selection and direction
    function automatic booth_ctrl_t booth_decode(input logic [2:0] bits);
        booth_ctrl_t c;
        c.sel = SEL_ZERO;
        c.sub = 1'b0;
        case (bits)
            OP_ADD_M_A, OP_ADD_M_B: c.sel = SEL_M;
            OP_ADD_2M:              c.sel = SEL_2M;
            OP_SUB_2M:              begin c.sel = SEL_2M; c.sub = 1'b1; end
            OP_SUB_M_A, OP_SUB_M_B: begin c.sel = SEL_M;  c.sub = 1'b1; end
            default:                c.sel = SEL_ZERO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// 34-bit adder/subtractor for one Booth step: operand +/- {0, M, 2M},
// with M sign-extended to the accumulator width.
module booth_addsub
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0]  i_operand,
    input  logic [DATA_W-1:0] i_m,
    input  booth_sel_t        i_sel,
    input  logic              i_sub,
    output logic [ACC_W-1:0]  o_sum
);

    logic [ACC_W-1:0] w_addend;

    // Select the sign-extended multiple of M
    always_comb begin
        w_addend = '0;
        case (i_sel)
            SEL_M:   w_addend = {{2{i_m[DATA_W-1]}}, i_m};
            SEL_2M:  w_addend = {i_m[DATA_W-1], i_m, 1'b0};
            default: w_addend = '0;
        endcase
    end

    assign o_sum = i_sub ? (i_operand - w_addend) : (i_operand + w_addend);

endmodule

// File: rtl/mult_booth_iter.sv
// Iterative signed 32x32 radix-4 Booth multiplier, 16 iterations.
// Optional overflow flag enabled by defining MULT_OVF_DETECT_EN.
module mult_booth_iter
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_mult,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0] r_q;
    logic              r_qm1;
    logic [DATA_W-1:0] r_m;
    logic [4:0]        r_cnt;

    logic              w_load;
    logic              w_step;
    booth_ctrl_t       w_ctrl;
    logic [ACC_W-1:0]  w_sum;
    logic [66:0]       w_cat;
    logic [66:0]       w_shifted;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and status outputs; a start strobe wins in every state
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_step         = 1'b0;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (r_state)
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == 5'(ITER_COUNT - 1)) w_state_nxt = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (ctrl_mult) begin
            w_load      = 1'b1;
            w_step      = 1'b0;
            w_state_nxt = RUN;
        end
    end

    assign w_ctrl = booth_decode({r_q[1:0], r_qm1});

    booth_addsub u_addsub (
        .i_operand (r_acc),
        .i_m       (r_m),
        .i_sel     (w_ctrl.sel),
        .i_sub     (w_ctrl.sub),
        .o_sum     (w_sum)
    );

    assign w_cat     = {w_sum, r_q, r_qm1};
    assign w_shifted = {{2{w_cat[66]}}, w_cat[66:2]};

    // Datapath: load on start, one add-and-shift step per RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= '0;
            r_q   <= data_operandB;
            r_qm1 <= 1'b0;
            r_m   <= data_operandA;
            r_cnt <= '0;
        end else if (w_step) begin
            r_acc <= w_shifted[66:33];
            r_q   <= w_shifted[32:1];
            r_qm1 <= w_shifted[0];
            r_cnt <= r_cnt + 5'd1;
        end
    end

    assign data_result = r_q;

`ifdef MULT_OVF_DETECT_EN
    // Product fits in 32 signed bits only if bits [63:31] are all equal
    logic [DATA_W:0] w_ovf_bits;
    assign w_ovf_bits     = {r_acc[DATA_W-1:0], r_q[DATA_W-1]};
    assign data_exception = ~busy & ~((&w_ovf_bits) | ~(|w_ovf_bits));
`else
    assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_mult_booth_iter.sv
// Self-checking bench for mult_booth_iter: directed, restart, reset and
// random products checked against signed 64-bit arithmetic.
module tb_mult_booth_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_mult;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef MULT_OVF_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    mult_booth_iter dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_mult      (ctrl_mult),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    function automatic logic model_exc(input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        p  = longint'($signed(a)) * longint'($signed(b));
        lo = p[31:0];
        return OVF_EN && (p != longint'(int'(lo)));
    endfunction

    // Caller is at a negedge; start edge is the next posedge
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        ctrl_mult     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clk);
        ctrl_mult     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Called right after start_op; checks busy/RDY timing, result and flag
    task automatic await_result(input logic [31:0] a, input logic [31:0] b,
                                input string tag, input bit check_hold);
        logic [31:0] er;
        logic        ee;
        er = model_result(a, b);
        ee = model_exc(a, b);
        n_cmp++;
        if (busy !== 1'b1 || data_resultRDY !== 1'b0 || data_result !== b) begin
            n_fail++;
            $display("FAIL %s start: busy=%b rdy=%b result=%h, required busy=1 rdy=0 result=%h",
                     tag, busy, data_resultRDY, data_result, b);
        end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                n_cmp++;
                if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s run cycle %0d: rdy=%b busy=%b, required rdy=0 busy=1",
                             tag, i, data_resultRDY, busy);
                end
            end
        end
        n_cmp++;
        if (data_resultRDY !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s latency: rdy=%b busy=%b, required rdy=1 busy=0",
                     tag, data_resultRDY, busy);
        end
        n_cmp++;
        if (data_result !== er) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h (A=%h B=%h)", tag, data_result, er, a, b);
        end
        n_cmp++;
        if (data_exception !== ee) begin
            n_fail++;
            $display("FAIL %s exception: got %b, required %b (A=%h B=%h)", tag, data_exception, ee, a, b);
        end
        if (check_hold) begin
            @(negedge clk);
            n_cmp++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== er || data_exception !== ee) begin
                n_fail++;
                $display("FAIL %s hold: rdy=%b busy=%b result=%h exc=%b, required rdy=0 busy=0 result=%h exc=%b",
                         tag, data_resultRDY, busy, data_result, data_exception, er, ee);
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: result=%h exc=%b rdy=%b busy=%b, required all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset: result=%h exc=%b rdy=%b busy=%b, required all 0",
                         data_result, data_exception, data_resultRDY, busy);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] da [5];
        logic [31:0] db [5];
        da = '{32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        db = '{32'd5, 32'd6,         32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            start_op(da[i], db[i]);
            await_result(da[i], db[i], $sformatf("directed%0d", i), 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        start_op(32'd1234, 32'hFFFF_FF00);
        await_result(32'd1234, 32'hFFFF_FF00, "b2b_first", 1'b0);
        start_op(32'h0001_0000, 32'h0001_0000);
        await_result(32'h0001_0000, 32'h0001_0000, "b2b_second", 1'b1);
    endtask

    task automatic test_abort();
        start_op(32'd3, 32'd5);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_pre cycle %0d: rdy=%b busy=%b, required rdy=0 busy=1",
                         i, data_resultRDY, busy);
            end
        end
        start_op(32'd4, 32'd4);
        await_result(32'd4, 32'd4, "abort_restart", 1'b1);
    endtask

    task automatic test_reset_midop();
        start_op(32'd3, 32'd5);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: result=%h exc=%b rdy=%b busy=%b, required all 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) reset = 1'b0;
            n_cmp++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_no_rdy cycle %0d: rdy=%b busy=%b result=%h, required 0 0 0",
                         i, data_resultRDY, busy, data_result);
            end
        end
        start_op(32'd2, 32'd2);
        await_result(32'd2, 32'd2, "after_reset", 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) a = 32'($urandom_range(0, 64)) - 32'd32;
            if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 64)) - 32'd32;
            start_op(a, b);
            await_result(a, b, $sformatf("random%0d", i), 1'b1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_mult     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
